status_scan_ctrl: RTL

- Sequencer for the status-detection datapath.
- Accepts a parallel operand word on a start strobe and streams it LSB-first, one bit per cycle, with a per-bit valid/go strobe.
- Accumulates status flags (zero, sign, parity, ones count, all-ones) while streaming, then reports them with a one-cycle done pulse.
- Sits between the operand source and the serial status detector; it owns all go-strobe timing.

---
 rtl/status_scan_ctrl_if.sv | 28 ++
 rtl/status_scan_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/status_scan_ctrl_if.sv
// Operand/flag bundle between the operand source (master) and status_scan_ctrl (slave).
interface status_scan_ctrl_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH + 1);

  logic             start;
  logic [WIDTH-1:0] data_in;
  logic             busy;
  logic             bit_out;
  logic             go;
  logic             done;
  logic             zero;
  logic             sign;
  logic             parity;
  logic [CW-1:0]    ones;
  logic             all_ones;

  modport master (
    output start, data_in,
    input  busy, bit_out, go, done, zero, sign, parity, ones, all_ones
  );

  modport slave (
    input  start, data_in,
    output busy, bit_out, go, done, zero, sign, parity, ones, all_ones
  );
endinterface

// File: rtl/status_scan_ctrl.sv
// Streams an operand LSB-first with a per-bit go strobe and accumulates
// zero/sign/parity/ones/all_ones flags, reported with a one-cycle done pulse.
module status_scan_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  status_scan_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SCAN = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  function automatic logic par_step(input logic acc, input logic b);
    return acc ^ b;
  endfunction

  state_t           state_r, state_nxt_s;
  logic [WIDTH-1:0] shreg_r, shreg_nxt_s;
  logic [CW-1:0]    idx_r, idx_nxt_s;
  logic [CW-1:0]    ones_r, ones_nxt_s;
  logic             parity_r, parity_nxt_s;
  logic             zero_r, zero_nxt_s;
  logic             sign_r, sign_nxt_s;
  logic             all_ones_r, all_ones_nxt_s;
  logic             go_r, bit_out_r, done_r;
  logic             scan_bit_s;
  logic             busy_s;

  // Next-state and datapath update; flags are finalised on the SCAN->DONE edge.
  always_comb begin
    state_nxt_s    = state_r;
    shreg_nxt_s    = shreg_r;
    idx_nxt_s      = idx_r;
    ones_nxt_s     = ones_r;
    parity_nxt_s   = parity_r;
    zero_nxt_s     = zero_r;
    sign_nxt_s     = sign_r;
    all_ones_nxt_s = all_ones_r;
    scan_bit_s     = shreg_r[0];

    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_nxt_s    = ST_SCAN;
          shreg_nxt_s    = bus.data_in;
          idx_nxt_s      = {CW{1'b0}};
          ones_nxt_s     = {CW{1'b0}};
          parity_nxt_s   = 1'b0;
          zero_nxt_s     = 1'b0;
          sign_nxt_s     = 1'b0;
          all_ones_nxt_s = 1'b0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SCAN: begin
        shreg_nxt_s  = {1'b0, shreg_r[WIDTH-1:1]};
        ones_nxt_s   = ones_r + {{(CW-1){1'b0}}, scan_bit_s};
        parity_nxt_s = par_step(parity_r, scan_bit_s);
        idx_nxt_s    = idx_r + {{(CW-1){1'b0}}, 1'b1};
        if (idx_r == LAST_IDX) begin
          state_nxt_s    = ST_DONE;
          zero_nxt_s     = (ones_nxt_s == {CW{1'b0}});
          all_ones_nxt_s = (ones_nxt_s == FULL_CNT);
          sign_nxt_s     = scan_bit_s;
        end else begin
          state_nxt_s = ST_SCAN;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, datapath and output registers; go/bit_out/done are decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      shreg_r    <= {WIDTH{1'b0}};
      idx_r      <= {CW{1'b0}};
      ones_r     <= {CW{1'b0}};
      parity_r   <= 1'b0;
      zero_r     <= 1'b0;
      sign_r     <= 1'b0;
      all_ones_r <= 1'b0;
      go_r       <= 1'b0;
      bit_out_r  <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      shreg_r    <= shreg_nxt_s;
      idx_r      <= idx_nxt_s;
      ones_r     <= ones_nxt_s;
      parity_r   <= parity_nxt_s;
      zero_r     <= zero_nxt_s;
      sign_r     <= sign_nxt_s;
      all_ones_r <= all_ones_nxt_s;
      go_r       <= (state_nxt_s == ST_SCAN);
      bit_out_r  <= (state_nxt_s == ST_SCAN) ? shreg_nxt_s[0] : 1'b0;
      done_r     <= (state_nxt_s == ST_DONE);
    end
  end

  assign busy_s       = (state_r == ST_SCAN) || (state_r == ST_DONE);
  assign bus.busy     = busy_s;
  assign bus.go       = go_r;
  assign bus.bit_out  = bit_out_r;
  assign bus.done     = done_r;
  assign bus.zero     = zero_r;
  assign bus.sign     = sign_r;
  assign bus.parity   = parity_r;
  assign bus.ones     = ones_r;
  assign bus.all_ones = all_ones_r;

  status_scan_ctrl_chk #(.WIDTH(WIDTH)) u_chk (
    .clk     (clk),
    .rst     (rst),
    .busy    (busy_s),
    .go      (go_r),
    .done    (done_r),
    .bit_out (bit_out_r),
    .ones    (ones_r)
  );
endmodule

// Protocol invariants of the scan sequencer outputs.
module status_scan_ctrl_chk #(
  parameter int WIDTH = 8
) (
  input logic                         clk,
  input logic                         rst,
  input logic                         busy,
  input logic                         go,
  input logic                         done,
  input logic                         bit_out,
  input logic [$clog2(WIDTH+1)-1:0]   ones
);
  localparam int CW = $clog2(WIDTH + 1);

  a_go_busy:   assert property (@(posedge clk) disable iff (rst) go |-> busy);
  a_done_busy: assert property (@(posedge clk) disable iff (rst) done |-> (busy && !go));
  a_done_once: assert property (@(posedge clk) disable iff (rst) done |=> !done);
  a_bit_quiet: assert property (@(posedge clk) disable iff (rst) !go |-> !bit_out);
  a_ones_max:  assert property (@(posedge clk) disable iff (rst) ones <= CW'(WIDTH));
endmodule
